// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs for ALU and LS feeding one registered ROB port.
// Define FU_WB_RR_EN for round-robin arbitration; without it the ALU has fixed priority.

`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif

package fu_wb_pkg;
  typedef logic [3:0] nzcv_t;

  typedef struct packed {
    logic [`ROB_IDX_SIZE-1:0] rob_idx;
    logic [`GPR_SIZE-1:0]     value;
    logic                     set_nzcv;
    nzcv_t                    nzcv;
    logic                     cond;
  } wb_res_t;
endpackage

// Small circular FIFO; ready depends on count only, so a full FIFO never accepts
// even while being popped.
module fu_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         ready_o,
  output logic         nempty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign ready_o  = (cnt_q < (AW+1)'(DEPTH));
  assign nempty_o = (cnt_q != '0);
  assign do_push  = valid_i & ready_o;
  assign do_pop   = pop_i & nempty_o;
  assign dout_o   = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end
endmodule

module fu_wb_arbiter
  import fu_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic                     in_flush,
  input  logic                     in_alu_valid,
  input  logic [`ROB_IDX_SIZE-1:0] in_alu_dst_rob_index,
  input  logic [`GPR_SIZE-1:0]     in_alu_value,
  input  logic                     in_alu_set_nzcv,
  input  nzcv_t                    in_alu_nzcv,
  input  logic                     in_alu_condition,
  output logic                     out_alu_ready,
  input  logic                     in_ls_valid,
  input  logic [`ROB_IDX_SIZE-1:0] in_ls_dst_rob_index,
  input  logic [`GPR_SIZE-1:0]     in_ls_value,
  output logic                     out_ls_ready,
  input  logic                     in_rob_ready,
  output logic                     out_rob_done,
  output logic [`ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic [`GPR_SIZE-1:0]     out_rob_value,
  output logic                     out_rob_set_nzcv,
  output nzcv_t                    out_rob_nzcv,
  output logic                     out_rob_condition,
  output logic                     out_idle
);
  localparam int RW = $bits(wb_res_t);

  wb_res_t alu_in, ls_in, alu_head, ls_head, out_q, out_d;
  logic    done_q, done_d;
  logic    alu_ne, ls_ne, free, prefer_alu, grant_alu, grant_ls;

  always_comb begin
    alu_in = '{rob_idx: in_alu_dst_rob_index, value: in_alu_value,
               set_nzcv: in_alu_set_nzcv, nzcv: in_alu_nzcv, cond: in_alu_condition};
    // LS results never carry flags or a condition bit.
    ls_in  = '{rob_idx: in_ls_dst_rob_index, value: in_ls_value,
               set_nzcv: 1'b0, nzcv: 4'b0000, cond: 1'b0};
  end

  fu_wb_fifo #(.DEPTH(DEPTH), .W(RW)) u_alu_fifo (
    .clk(in_clk), .rst_n(in_rst_n), .flush_i(in_flush),
    .valid_i(in_alu_valid), .pop_i(grant_alu), .din_i(alu_in),
    .dout_o(alu_head), .ready_o(out_alu_ready), .nempty_o(alu_ne)
  );

  fu_wb_fifo #(.DEPTH(DEPTH), .W(RW)) u_ls_fifo (
    .clk(in_clk), .rst_n(in_rst_n), .flush_i(in_flush),
    .valid_i(in_ls_valid), .pop_i(grant_ls), .din_i(ls_in),
    .dout_o(ls_head), .ready_o(out_ls_ready), .nempty_o(ls_ne)
  );

`ifdef FU_WB_RR_EN
  logic last_ls_q;

  // Last grant starts at LS so the ALU takes the first contention.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n)      last_ls_q <= 1'b1;
    else if (in_flush)  last_ls_q <= 1'b1;
    else if (grant_alu) last_ls_q <= 1'b0;
    else if (grant_ls)  last_ls_q <= 1'b1;
  end

  assign prefer_alu = last_ls_q;
`else
  assign prefer_alu = 1'b1;
`endif

  assign free      = !done_q || in_rob_ready;
  assign grant_alu = free && alu_ne && (!ls_ne || prefer_alu);
  assign grant_ls  = free && ls_ne && !grant_alu;

  always_comb begin
    done_d = done_q;
    out_d  = out_q;
    if (free) begin
      done_d = grant_alu || grant_ls;
      if (grant_alu)     out_d = alu_head;
      else if (grant_ls) out_d = ls_head;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      done_q <= 1'b0;
      out_q  <= '0;
    end else if (in_flush) begin
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      done_q <= done_d;
      out_q  <= out_d;
    end
  end

  assign out_rob_done          = done_q;
  assign out_rob_dst_rob_index = out_q.rob_idx;
  assign out_rob_value         = out_q.value;
  assign out_rob_set_nzcv      = out_q.set_nzcv;
  assign out_rob_nzcv          = out_q.nzcv;
  assign out_rob_condition     = out_q.cond;
  assign out_idle              = !alu_ne && !ls_ne && !done_q;
endmodule
